uart_tx_fifo_reader: RTL and testbench

- Transmit-side consumer of the UART sync FIFO: pops one byte at a time and serialises it onto the tx line as an 8N1-style frame.
- Frame format is parameterised: parity and 1/2 stop bits.
- Sits between the TX FIFO (push side owned by the host/bus logic) and the pad.
- Matches the FIFO's registered data_out and registered, one-cycle-lagging fifo_empty.

---
 rtl/uart_tx_fifo_reader.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_reader.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo_reader : pops bytes from the TX FIFO and serialises UART frames
// Revision 1.0
// ============================================================================
module uart_tx_fifo_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  tx_enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  tx_o,
  output logic                  tx_busy_o,
  output logic                  tx_done_o
);

  localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_BIT_W  = $clog2(DATA_WIDTH + 2);

  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
  localparam logic [c_BIT_W-1:0]  c_BIT_ONE   = c_BIT_W'(1);
  localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(DATA_WIDTH - 1);
  localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_POP    = 3'd1;
  localparam logic [2:0] c_LOAD   = 3'd2;
  localparam logic [2:0] c_START  = 3'd3;
  localparam logic [2:0] c_DATA   = 3'd4;
  localparam logic [2:0] c_PARITY = 3'd5;
  localparam logic [2:0] c_STOP   = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [c_BAUD_W-1:0]   baud_q, baud_d;
  logic [c_BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  fifo_pop_q, fifo_pop_d;
  logic                  tx_q, tx_d;
  logic                  tx_busy_q, tx_busy_d;
  logic                  tx_done_q, tx_done_d;
  logic                  bit_end;

  assign bit_end = (baud_q == c_BAUD_LAST);

  // Baud counter defaults to 0 so it idles at zero outside the bit-timed states.
  always_comb begin
    state_d  = state_q;
    baud_d   = '0;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    case (state_q)
      c_IDLE: begin
        if (tx_enable_i && !fifo_empty_i) begin
          state_d = c_POP;
        end
      end
      c_POP: begin
        state_d = c_LOAD;
      end
      c_LOAD: begin
        state_d  = c_START;
        shift_d  = fifo_data_i;
        parity_d = (^fifo_data_i) ^ (PARITY_ODD != 0);
        bit_d    = '0;
      end
      c_START: begin
        if (bit_end) begin
          state_d = c_DATA;
        end else begin
          baud_d = baud_q + c_BAUD_ONE;
        end
      end
      c_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == c_DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? c_PARITY : c_STOP;
          end else begin
            bit_d = bit_q + c_BIT_ONE;
          end
        end else begin
          baud_d = baud_q + c_BAUD_ONE;
        end
      end
      c_PARITY: begin
        if (bit_end) begin
          state_d = c_STOP;
        end else begin
          baud_d = baud_q + c_BAUD_ONE;
        end
      end
      c_STOP: begin
        if (bit_end) begin
          if (bit_q == c_STOP_LAST) begin
            bit_d   = '0;
            state_d = c_IDLE;
          end else begin
            bit_d = bit_q + c_BIT_ONE;
          end
        end else begin
          baud_d = baud_q + c_BAUD_ONE;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    fifo_pop_d = (state_d == c_POP);
    tx_busy_d  = (state_d != c_IDLE);
    tx_done_d  = (state_q == c_STOP) && (state_d == c_IDLE);
    case (state_d)
      c_START:  tx_d = 1'b0;
      c_DATA:   tx_d = shift_d[0];
      c_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= c_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      fifo_pop_q <= 1'b0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      fifo_pop_q <= fifo_pop_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign fifo_pop_o = fifo_pop_q;
  assign tx_o       = tx_q;
  assign tx_busy_o  = tx_busy_q;
  assign tx_done_o  = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_reader.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_fifo_reader : three frame formats fed from FIFO models, checked
// cycle by cycle against a frame-level timing model.
// Revision 1.0
// ============================================================================
module tb_uart_tx_fifo_reader;

  localparam int NDUT = 3;
  localparam int MAXB = 8;

  function automatic int cfg_cpb(input int d);
    return (d == 1) ? 5 : 4;
  endfunction
  function automatic int cfg_pen(input int d);
    return (d == 0) ? 0 : 1;
  endfunction
  function automatic int cfg_podd(input int d);
    return (d == 1) ? 1 : 0;
  endfunction
  function automatic int cfg_stop(input int d);
    return (d == 1) ? 2 : 1;
  endfunction
  function automatic int frame_len(input int d);
    return cfg_cpb(d) * (1 + 8 + cfg_pen(d) + cfg_stop(d));
  endfunction

  logic            clk       = 1'b0;
  logic            rst       = 1'b0;
  logic            tx_enable = 1'b0;
  logic            push_v    = 1'b0;
  logic [7:0]      push_d    = 8'h00;
  logic [NDUT-1:0] empty_v, pop_v, tx_v, busy_v, done_v;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [7:0] mem [16];
    logic [3:0] wp, rp;
    logic [7:0] dout;
    logic       empty_q;

    always_ff @(posedge clk) begin
      if (push_v && !rst) mem[wp] <= push_d;
    end

    // Registered data_out and an empty flag that lags the count by one cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wp      <= 4'd0;
        rp      <= 4'd0;
        dout    <= 8'h00;
        empty_q <= 1'b1;
      end else begin
        if (push_v) wp <= wp + 4'd1;
        if (pop_v[g]) begin
          dout <= mem[rp];
          rp   <= rp + 4'd1;
        end
        empty_q <= (wp == rp);
      end
    end
    assign empty_v[g] = empty_q;

    uart_tx_fifo_reader #(
      .DATA_WIDTH  (8),
      .CLKS_PER_BIT(cfg_cpb(g)),
      .PARITY_EN   (cfg_pen(g)),
      .PARITY_ODD  (cfg_podd(g)),
      .STOP_BITS   (cfg_stop(g))
    ) u_dut (
      .clock_i     (clk),
      .reset_i     (rst),
      .tx_enable_i (tx_enable),
      .fifo_empty_i(empty_v[g]),
      .fifo_data_i (dout),
      .fifo_pop_o  (pop_v[g]),
      .tx_o        (tx_v[g]),
      .tx_busy_o   (busy_v[g]),
      .tx_done_o   (done_v[g])
    );
  end

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] bq [MAXB];
  int         nb;
  int         starts [NDUT][MAXB];
  int         en_lo_a = 0;
  int         en_lo_b = 0;

  function automatic bit en_at(input int c);
    return !(c >= en_lo_a && c < en_lo_b);
  endfunction

  // Byte k is pushed in cycle k and is visible to the reader two cycles later;
  // a frame starts three cycles after the IDLE cycle that accepts it.
  task automatic plan();
    int t;
    for (int d = 0; d < NDUT; d++) begin
      t = 0;
      for (int k = 0; k < nb; k++) begin
        if (t < k + 2) t = k + 2;
        while (!en_at(t)) t++;
        starts[d][k] = t + 3;
        t = t + 3 + frame_len(d);
      end
    end
  endtask

  // Returns {tx, pop, busy, done} expected in cycle c.
  function automatic logic [3:0] expect_out(input int d, input int c);
    logic tx, pop, busy, done;
    int   s, f, b;
    tx = 1'b1; pop = 1'b0; busy = 1'b0; done = 1'b0;
    f  = frame_len(d);
    for (int k = 0; k < nb; k++) begin
      s = starts[d][k];
      if (c == s - 2) pop = 1'b1;
      if (c >= s - 2 && c < s + f) busy = 1'b1;
      if (c == s + f) done = 1'b1;
      if (c >= s && c < s + f) begin
        b = (c - s) / cfg_cpb(d);
        if (b == 0) tx = 1'b0;
        else if (b <= 8) tx = bq[k][b-1];
        else if (cfg_pen(d) != 0 && b == 9) tx = (^bq[k]) ^ (cfg_podd(d) != 0);
      end
    end
    return {tx, pop, busy, done};
  endfunction

  task automatic check(input string tag, input int d, input int c, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d cycle %0d: observed %b expected %b", tag, d, c, obs, exp);
    end
  endtask

  task automatic run(input string name, input int ncyc_req);
    int         ncyc;
    logic [3:0] e;
    plan();
    ncyc = nb + 20;
    for (int d = 0; d < NDUT; d++)
      for (int k = 0; k < nb; k++)
        if (starts[d][k] + frame_len(d) + 6 > ncyc) ncyc = starts[d][k] + frame_len(d) + 6;
    if (ncyc_req > 0) ncyc = ncyc_req;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        e = expect_out(d, c);
        check({name, ".tx"},   d, c, tx_v[d],   e[3]);
        check({name, ".pop"},  d, c, pop_v[d],  e[2]);
        check({name, ".busy"}, d, c, busy_v[d], e[1]);
        check({name, ".done"}, d, c, done_v[d], e[0]);
      end
      tx_enable = en_at(c);
      push_v    = (c < nb);
      push_d    = (c < nb) ? bq[c] : 8'h00;
    end
    tx_enable = 1'b0;
    push_v    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    for (int d = 0; d < NDUT; d++) begin
      check({name, ".tx"},   d, -1, tx_v[d],   1'b1);
      check({name, ".pop"},  d, -1, pop_v[d],  1'b0);
      check({name, ".busy"}, d, -1, busy_v[d], 1'b0);
      check({name, ".done"}, d, -1, done_v[d], 1'b0);
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #2 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    nb = 1; bq[0] = 8'hA5;
    run("a5", 0);

    nb = 1; bq[0] = 8'h07;
    run("p07", 0);

    nb = 3; bq[0] = 8'h11; bq[1] = 8'h22; bq[2] = 8'h33;
    run("stream", 0);

    nb = 2; bq[0] = 8'($urandom); bq[1] = 8'($urandom);
    en_lo_a = 12; en_lo_b = 150;
    run("gate", 0);
    en_lo_a = 0; en_lo_b = 0;

    nb = 1; bq[0] = 8'h00;
    run("zero", 0);

    for (int r = 0; r < 2; r++) begin
      nb = 5;
      for (int k = 0; k < nb; k++) bq[k] = 8'($urandom);
      run("rand", 0);
    end

    nb = 1; bq[0] = 8'hC3;
    run("prerst", 20);
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nb = 0;
    en_lo_a = 0; en_lo_b = 0;
    run("postrst", 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
